// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl_if
//  Purpose  : Bundle of IR fields, flags, memory handshake and datapath
//             controls exchanged between the multi-cycle controller and
//             its datapath/memory.
//  Revision : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       EQ;
    logic       mem_ready;

    logic       mem_req;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic [1:0] ALUsrcA;
    logic [1:0] ALUsrcB;
    logic [2:0] ALUctrl;
    logic [1:0] ImmSrc;
    logic [1:0] ResultSrc;
    logic       fault;
    logic [3:0] state_dbg;

    // Controller side
    modport master (
        input  op, funct3, EQ, mem_ready,
        output mem_req, AdrSrc, IRWrite, PCWrite, RegWrite,
               ALUsrcA, ALUsrcB, ALUctrl, ImmSrc, ResultSrc,
               fault, state_dbg
    );

    // Datapath / memory side
    modport slave (
        output op, funct3, EQ, mem_ready,
        input  mem_req, AdrSrc, IRWrite, PCWrite, RegWrite,
               ALUsrcA, ALUsrcB, ALUctrl, ImmSrc, ResultSrc,
               fault, state_dbg
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl
//  Purpose  : Fetch/decode/execute/memory/writeback sequencer for the RV32I
//             addi, lw and bne subset, with a shared memory port and a
//             bounded wait on mem_ready.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.master  bus
);

    localparam int                 CNT_W       = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]   C_CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [6:0]         C_OP_IMM    = 7'b0010011;
    localparam logic [6:0]         C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0]         C_OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXEC_I  = 4'd2,
        S_ALU_WB  = 4'd3,
        S_MEM_ADR = 4'd4,
        S_MEM_RD  = 4'd5,
        S_MEM_WB  = 4'd6,
        S_BRANCH  = 4'd7,
        S_FAULT   = 4'd8
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       w_timeout;
    logic       w_mem_req, w_adr_src, w_ir_write, w_pc_write, w_reg_write;
    logic [1:0] w_alu_a, w_alu_b, w_imm_src, w_result_src;
    logic [2:0] w_alu_ctrl;
    logic       w_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter defaults to zero, so every exit from a wait state (and
    // thus every entry into FETCH or MEM_RD) starts a fresh window.
    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        w_timeout    = (cnt_q == C_CNT_LAST) && !bus.mem_ready;
        w_mem_req    = 1'b0;
        w_adr_src    = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_a      = 2'b00;
        w_alu_b      = 2'b00;
        w_alu_ctrl   = 3'b000;
        w_imm_src    = 2'b00;
        w_result_src = 2'b00;
        w_fault      = 1'b0;

        case (state_q)
            S_FETCH: begin
                w_mem_req    = 1'b1;
                w_alu_b      = 2'b10;
                w_result_src = 2'b10;
                w_ir_write   = bus.mem_ready;
                w_pc_write   = bus.mem_ready;
                if (bus.mem_ready)  state_d = S_DECODE;
                else if (w_timeout) state_d = S_FAULT;
                else                cnt_d   = cnt_q + CNT_W'(1);
            end
            S_DECODE: begin
                w_alu_a   = 2'b01;
                w_alu_b   = 2'b01;
                w_imm_src = 2'b10;
                if      (bus.op == C_OP_IMM    && bus.funct3 == 3'b000) state_d = S_EXEC_I;
                else if (bus.op == C_OP_LOAD   && bus.funct3 == 3'b010) state_d = S_MEM_ADR;
                else if (bus.op == C_OP_BRANCH && bus.funct3 == 3'b001) state_d = S_BRANCH;
                else                                                    state_d = S_FAULT;
            end
            S_EXEC_I: begin
                w_alu_a = 2'b10;
                w_alu_b = 2'b01;
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                w_reg_write = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEM_ADR: begin
                w_alu_a = 2'b10;
                w_alu_b = 2'b01;
                state_d = S_MEM_RD;
            end
            S_MEM_RD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
                if (bus.mem_ready)  state_d = S_MEM_WB;
                else if (w_timeout) state_d = S_FAULT;
                else                cnt_d   = cnt_q + CNT_W'(1);
            end
            S_MEM_WB: begin
                w_reg_write  = 1'b1;
                w_result_src = 2'b01;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_a    = 2'b10;
                w_alu_ctrl = 3'b001;
                w_pc_write = ~bus.EQ;
                state_d    = S_FETCH;
            end
            S_FAULT: begin
                w_fault = 1'b1;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    // Reset masks every control output so no write enable can fire during it.
    assign bus.mem_req   = w_mem_req   & ~rst;
    assign bus.AdrSrc    = w_adr_src   & ~rst;
    assign bus.IRWrite   = w_ir_write  & ~rst;
    assign bus.PCWrite   = w_pc_write  & ~rst;
    assign bus.RegWrite  = w_reg_write & ~rst;
    assign bus.ALUsrcA   = rst ? 2'b00  : w_alu_a;
    assign bus.ALUsrcB   = rst ? 2'b00  : w_alu_b;
    assign bus.ALUctrl   = rst ? 3'b000 : w_alu_ctrl;
    assign bus.ImmSrc    = rst ? 2'b00  : w_imm_src;
    assign bus.ResultSrc = rst ? 2'b00  : w_result_src;
    assign bus.fault     = w_fault     & ~rst;
    assign bus.state_dbg = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_ctrl
//  Purpose  : Self-checking bench for multicycle_ctrl: vector table, corner
//             sequences and randomized instruction streams.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_R   = 7'b0110011;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          r;
        logic [6:0]  op;
        logic [2:0]  f3;
        bit          eq;
        bit          mr;
        logic [20:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Expected control word for a given state, straight from the per-state signal list.
    function automatic logic [20:0] eo(input int st, input bit mr, input bit eq, input bit r);
        logic       mreq, adr, irw, pcw, rw, f;
        logic [1:0] a, b, imm, res;
        logic [2:0] alu;
        logic [3:0] s;
        {mreq, adr, irw, pcw, rw, f} = '0;
        {a, b, imm, res} = '0;
        alu = '0;
        s = st[3:0];
        case (st)
            0: begin mreq = 1; b = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
            1: begin a = 2'b01; b = 2'b01; imm = 2'b10; end
            2: begin a = 2'b10; b = 2'b01; end
            3: begin rw = 1; end
            4: begin a = 2'b10; b = 2'b01; end
            5: begin mreq = 1; adr = 1; end
            6: begin rw = 1; res = 2'b01; end
            7: begin a = 2'b10; alu = 3'b001; pcw = ~eq; end
            8: begin f = 1; end
            default: ;
        endcase
        if (r) return {17'b0, s};
        return {mreq, adr, irw, pcw, rw, a, b, alu, imm, res, f, s};
    endfunction

    // Instruction class decided by the decode rules: next state after DECODE.
    function automatic int target(input logic [6:0] op, input logic [2:0] f3);
        if (op == OP_IMM && f3 == 3'b000) return 2;
        if (op == OP_LD  && f3 == 3'b010) return 4;
        if (op == OP_BR  && f3 == 3'b001) return 7;
        return 8;
    endfunction

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic step_v(input bit r, input bit mr, input bit eq,
                          input logic [20:0] exp, input string nm);
        logic [20:0] act;
        rst           = r;
        bus.mem_ready = mr;
        bus.EQ        = eq;
        @(negedge clk);
        act = {bus.mem_req, bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.RegWrite,
               bus.ALUsrcA, bus.ALUsrcB, bus.ALUctrl, bus.ImmSrc, bus.ResultSrc,
               bus.fault, bus.state_dbg};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h (state %0d) expected %h (state %0d)",
                     nm, $time, act, act[3:0], exp, exp[3:0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit r, input bit mr, input bit eq, input int st, input string nm);
        step_v(r, mr, eq, eo(st, mr, eq, r), nm);
    endtask

    task automatic add(input bit r, input logic [6:0] op, input logic [2:0] f3,
                       input bit eq, input bit mr, input int st);
        vec_t v;
        v.r = r; v.op = op; v.f3 = f3; v.eq = eq; v.mr = mr;
        v.exp = eo(st, mr, eq, r);
        tbl.push_back(v);
    endtask

    // One instruction with wf fetch waits and wm load waits (both below the limit).
    task automatic run_random_instr(input int idx);
        logic [6:0] op;
        logic [2:0] f3;
        int         kind, wf, wm, t;
        kind = $urandom_range(0, 3);
        case (kind)
            0:       begin op = OP_IMM; f3 = 3'b000; end
            1:       begin op = OP_LD;  f3 = 3'b010; end
            2:       begin op = OP_BR;  f3 = 3'b001; end
            default: begin op = 7'($urandom); f3 = 3'($urandom); end
        endcase
        wf = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
        wm = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
        bus.op = op;
        bus.funct3 = f3;
        for (int i = 0; i < wf; i++) step(0, 0, rb(), 0, $sformatf("rnd%0d_fetch_wait", idx));
        step(0, 1, rb(), 0, $sformatf("rnd%0d_fetch", idx));
        step(0, rb(), rb(), 1, $sformatf("rnd%0d_decode", idx));
        t = target(op, f3);
        case (t)
            2: begin
                step(0, rb(), rb(), 2, $sformatf("rnd%0d_exec", idx));
                step(0, rb(), rb(), 3, $sformatf("rnd%0d_aluwb", idx));
            end
            4: begin
                step(0, rb(), rb(), 4, $sformatf("rnd%0d_memadr", idx));
                for (int i = 0; i < wm; i++) step(0, 0, rb(), 5, $sformatf("rnd%0d_memrd_wait", idx));
                step(0, 1, rb(), 5, $sformatf("rnd%0d_memrd", idx));
                step(0, rb(), rb(), 6, $sformatf("rnd%0d_memwb", idx));
            end
            7: begin
                step(0, rb(), rb(), 7, $sformatf("rnd%0d_branch", idx));
            end
            default: begin
                step(0, rb(), rb(), 8, $sformatf("rnd%0d_fault", idx));
                step(1, rb(), rb(), 8, $sformatf("rnd%0d_fault_rst", idx));
            end
        endcase
    endtask

    initial begin
        rst = 1'b1;
        bus.op = OP_IMM; bus.funct3 = 3'b000; bus.EQ = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset, then addi / bne x2 / lw with 2 waits / illegal ops
        add(1, OP_IMM, 3'b000, 0, 1, 0);
        add(0, OP_IMM, 3'b000, 0, 1, 0); add(0, OP_IMM, 3'b000, 0, 1, 1);
        add(0, OP_IMM, 3'b000, 0, 1, 2); add(0, OP_IMM, 3'b000, 0, 1, 3);
        add(0, OP_BR,  3'b001, 0, 1, 0); add(0, OP_BR,  3'b001, 0, 1, 1);
        add(0, OP_BR,  3'b001, 0, 1, 7);
        add(0, OP_BR,  3'b001, 1, 1, 0); add(0, OP_BR,  3'b001, 1, 1, 1);
        add(0, OP_BR,  3'b001, 1, 1, 7);
        add(0, OP_LD,  3'b010, 0, 1, 0); add(0, OP_LD,  3'b010, 0, 1, 1);
        add(0, OP_LD,  3'b010, 0, 1, 4); add(0, OP_LD,  3'b010, 0, 0, 5);
        add(0, OP_LD,  3'b010, 0, 0, 5); add(0, OP_LD,  3'b010, 0, 1, 5);
        add(0, OP_LD,  3'b010, 0, 1, 6);
        add(0, OP_R,   3'b000, 0, 1, 0); add(0, OP_R,   3'b000, 0, 1, 1);
        add(0, OP_R,   3'b000, 0, 1, 8); add(0, OP_R,   3'b000, 1, 1, 8);
        add(1, OP_R,   3'b000, 0, 1, 8);
        add(0, OP_IMM, 3'b001, 0, 1, 0); add(0, OP_IMM, 3'b001, 0, 1, 1);
        add(0, OP_IMM, 3'b001, 0, 1, 8); add(1, OP_IMM, 3'b001, 0, 1, 8);

        for (int i = 0; i < tbl.size(); i++) begin
            bus.op = tbl[i].op;
            bus.funct3 = tbl[i].f3;
            step_v(tbl[i].r, tbl[i].mr, tbl[i].eq, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // fault is sticky for 20 cycles regardless of inputs
        bus.op = OP_R; bus.funct3 = 3'b000;
        step(0, 1, 0, 0, "sticky_fetch");
        step(0, 1, 0, 1, "sticky_decode");
        for (int i = 0; i < 20; i++) step(0, rb(), rb(), 8, "sticky_hold");
        step(1, 1, 0, 8, "sticky_rst");

        // fetch timeout: FAULT exactly 16 cycles after FETCH entry
        bus.op = OP_IMM; bus.funct3 = 3'b000;
        for (int i = 0; i < 16; i++) step(0, 0, rb(), 0, "to_fetch_wait");
        step(0, rb(), rb(), 8, "to_fetch_fault");
        step(1, 1, 0, 8, "to_fetch_rst");

        // ready on the 16th cycle rescues the fetch
        for (int i = 0; i < 15; i++) step(0, 0, rb(), 0, "rescue_wait");
        step(0, 1, 0, 0, "rescue_fetch");
        step(0, 0, 0, 1, "rescue_decode");
        step(0, 0, 0, 2, "rescue_exec");
        step(0, 0, 0, 3, "rescue_aluwb");

        // reset while waiting in MEM_RD, then full windows in FETCH and MEM_RD
        bus.op = OP_LD; bus.funct3 = 3'b010;
        step(0, 1, 0, 0, "rmr_fetch");
        step(0, 0, 0, 1, "rmr_decode");
        step(0, 0, 0, 4, "rmr_memadr");
        for (int i = 0; i < 5; i++) step(0, 0, rb(), 5, "rmr_wait");
        step(1, 1, 1, 5, "rmr_rst");
        for (int i = 0; i < 15; i++) step(0, 0, rb(), 0, "rmr_fetch_wait");
        step(0, 1, 0, 0, "rmr_fetch2");
        step(0, 0, 0, 1, "rmr_decode2");
        step(0, 0, 0, 4, "rmr_memadr2");
        for (int i = 0; i < 16; i++) step(0, 0, rb(), 5, "rmr_memrd_wait");
        step(0, rb(), rb(), 8, "rmr_memrd_fault");
        step(1, 0, 0, 8, "rmr_fault_rst");

        for (int i = 0; i < 40; i++) run_random_instr(i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
